// File: rtl/adc_init_pkg.sv
// adc_init_pkg: shared types, frame layout and the default AD9648 command
// table for the ADC configuration sequencer.
package adc_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PWR_WAIT = 3'd1,
      ST_ISSUE    = 3'd2,
      ST_WAIT     = 3'd3,
      ST_CHECK    = 3'd4,
      ST_ISSUE_RD = 3'd5,
      ST_DONE     = 3'd6,
      ST_ERROR    = 3'd7
   } state_e;

   // 24-bit AD9648 SPI frame: {R/W, W1:W0, addr[12:0], data[7:0]}
   localparam int unsigned RW_BIT   = 23;
   localparam int unsigned ADDR_MSB = 20;
   localparam int unsigned ADDR_LSB = 8;
   localparam int unsigned FRAME_W  = 24;
   localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

   localparam logic [ADDR_W-1:0] ADDR_SPI_CFG    = 13'h000;
   localparam logic [ADDR_W-1:0] ADDR_DEV_UPDATE = 13'h0FF;
   localparam logic [7:0]        DEV_UPDATE_DATA = 8'h01;

   function automatic logic [FRAME_W-1:0] adc_make_frame(input logic              rd,
                                                         input logic [ADDR_W-1:0] addr,
                                                         input logic [7:0]        data);
      return {rd, 2'b00, addr, data};
   endfunction

   // Default bring-up table; the final entry latches all shadow registers.
   function automatic logic [FRAME_W-1:0] adc_init_table(input int unsigned idx);
      logic [FRAME_W-1:0] f;
      case (idx)
         0:       f = adc_make_frame(1'b0, ADDR_SPI_CFG, 8'h18); // SPI port config, MSB first
         1:       f = adc_make_frame(1'b0, 13'h005, 8'h03);      // device index: channels A and B
         2:       f = adc_make_frame(1'b0, 13'h019, 8'h5A);      // user test pattern 1 LSB
         3:       f = adc_make_frame(1'b0, 13'h014, 8'h01);      // output mode: two's complement
         4:       f = adc_make_frame(1'b0, 13'h008, 8'h00);      // power mode: normal
         5:       f = adc_make_frame(1'b0, 13'h016, 8'h00);      // clock phase control
         6:       f = adc_make_frame(1'b0, 13'h00D, 8'h00);      // test mode off
         default: f = adc_make_frame(1'b0, ADDR_DEV_UPDATE, DEV_UPDATE_DATA);
      endcase
      return f;
   endfunction

endpackage

// File: rtl/adc_init_timer.sv
// adc_init_timer: loadable down-counter that stops at zero and flags it.
// Shared between the power-up delay and the per-transfer timeout.
module adc_init_timer #(
   parameter int unsigned Width = 12
) (
   input  logic             clk_i,
   input  logic             rst_clk_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             tc_o
);

   logic [Width-1:0] cnt_q;

   // Load on request, otherwise count down and hold at zero.
   always_ff @(posedge clk_i or negedge rst_clk_i) begin
      if (!rst_clk_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/adc_init_sequencer.sv
// adc_init_sequencer: waits a power-up delay after start, then walks the
// AD9648 command table, handing each frame to the SPI control stage.
// Optional read-back verification with retry: define ADC_INIT_READBACK_EN.
module adc_init_sequencer
   import adc_init_pkg::*;
#(
   parameter int unsigned TxRegWidth    = 24,
   parameter int unsigned RxRegWidth    = 8,
   parameter int unsigned NumCmds       = 8,
   parameter int unsigned PwrUpCycles   = 1000,
   parameter int unsigned TimeoutCycles = 4096,
   parameter int unsigned MaxRetries    = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_clk_i,
   input  logic                       start_i,
   output logic [TxRegWidth-1:0]      tx_reg_o,
   output logic                       transfer_start_o,
   input  logic                       transfer_done_i,
   input  logic [RxRegWidth-1:0]      rx_reg_i,
   output logic                       config_done_o,
   output logic                       busy_o,
   output logic                       error_o,
   output logic [$clog2(NumCmds)-1:0] err_idx_o
);

   localparam int unsigned IdxW   = $clog2(NumCmds);
   localparam int unsigned TmrMax = (PwrUpCycles > TimeoutCycles) ? PwrUpCycles : TimeoutCycles;
   localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;

   localparam logic [TmrW-1:0] PwrLoad = TmrW'(PwrUpCycles - 1);
   localparam logic [TmrW-1:0] ToLoad  = TmrW'(TimeoutCycles - 1);

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [IdxW-1:0]       err_idx_q, err_idx_d;
   logic [TxRegWidth-1:0] tx_reg_q, tx_reg_d;
   logic                  tmr_load;
   logic [TmrW-1:0]       tmr_val;
   logic                  tmr_tc;
   logic                  is_last;
   logic                  advance;
   logic [FRAME_W-1:0]    cur_frame;
   logic [FRAME_W-1:0]    nxt_frame;

`ifdef ADC_INIT_READBACK_EN
   localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

   logic [RetryW-1:0]     retry_q, retry_d;
   logic                  rd_phase_q, rd_phase_d;
   logic [RxRegWidth-1:0] rx_q, rx_d;

   // Registers 0x000 and 0x0FF are not read back (self-clearing / strobe).
   function automatic logic needs_readback(input logic [FRAME_W-1:0] frame);
      logic [ADDR_W-1:0] addr;
      addr = frame[ADDR_MSB:ADDR_LSB];
      return (addr != ADDR_SPI_CFG) && (addr != ADDR_DEV_UPDATE);
   endfunction
`else
   logic unused_cfg;
   assign unused_cfg = ^{rx_reg_i, (MaxRetries == 0)};
`endif

   // The last entry is always forced to the device-update strobe.
   function automatic logic [FRAME_W-1:0] frame_at(input logic [IdxW-1:0] idx);
      logic [FRAME_W-1:0] f;
      if (32'(idx) == NumCmds - 1) begin
         f = adc_make_frame(1'b0, ADDR_DEV_UPDATE, DEV_UPDATE_DATA);
      end else begin
         f = adc_init_table(32'(idx));
      end
      return f;
   endfunction

   assign is_last = (32'(idx_q) == NumCmds - 1);

   adc_init_timer #(
      .Width(TmrW)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_clk_i  (rst_clk_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .tc_o       (tmr_tc)
   );

   // State, table index, captured frame and error index.
   always_ff @(posedge clk_i or negedge rst_clk_i) begin
      if (!rst_clk_i) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         err_idx_q <= '0;
         tx_reg_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         err_idx_q <= err_idx_d;
         tx_reg_q  <= tx_reg_d;
      end
   end

`ifdef ADC_INIT_READBACK_EN
   // Read-back bookkeeping: retry count, read/write phase, captured read data.
   always_ff @(posedge clk_i or negedge rst_clk_i) begin
      if (!rst_clk_i) begin
         retry_q    <= '0;
         rd_phase_q <= 1'b0;
         rx_q       <= '0;
      end else begin
         retry_q    <= retry_d;
         rd_phase_q <= rd_phase_d;
         rx_q       <= rx_d;
      end
   end
`endif

   // Next-state logic; tx_reg is loaded on entry to an issue state so the
   // frame stays stable for the whole transfer.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      err_idx_d = err_idx_q;
      tx_reg_d  = tx_reg_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      advance   = 1'b0;
      cur_frame = frame_at(idx_q);
      nxt_frame = frame_at(idx_q + 1'b1);
`ifdef ADC_INIT_READBACK_EN
      retry_d    = retry_q;
      rd_phase_d = rd_phase_q;
      rx_d       = rx_q;
`endif

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_i) begin
               state_d  = ST_PWR_WAIT;
               idx_d    = '0;
               tmr_load = 1'b1;
               tmr_val  = PwrLoad;
`ifdef ADC_INIT_READBACK_EN
               retry_d  = '0;
`endif
            end
         end

         ST_PWR_WAIT: begin
            if (tmr_tc) begin
               state_d  = ST_ISSUE;
               tx_reg_d = TxRegWidth'(cur_frame);
`ifdef ADC_INIT_READBACK_EN
               rd_phase_d = 1'b0;
`endif
            end
         end

         ST_ISSUE, ST_ISSUE_RD: begin
            tmr_load = 1'b1;
            tmr_val  = ToLoad;
            state_d  = ST_WAIT;
         end

         ST_WAIT: begin
            if (transfer_done_i) begin
               state_d = ST_CHECK;
`ifdef ADC_INIT_READBACK_EN
               rx_d    = rx_reg_i;
`endif
            end else if (tmr_tc) begin
               state_d   = ST_ERROR;
               err_idx_d = idx_q;
            end
         end

         ST_CHECK: begin
`ifdef ADC_INIT_READBACK_EN
            if (!rd_phase_q) begin
               if (needs_readback(cur_frame)) begin
                  state_d    = ST_ISSUE_RD;
                  rd_phase_d = 1'b1;
                  tx_reg_d   = TxRegWidth'(adc_make_frame(1'b1, cur_frame[ADDR_MSB:ADDR_LSB], 8'h00));
               end else begin
                  advance = 1'b1;
               end
            end else if (rx_q == RxRegWidth'(cur_frame[7:0])) begin
               advance = 1'b1;
            end else if (retry_q < RetryW'(MaxRetries)) begin
               retry_d    = retry_q + 1'b1;
               rd_phase_d = 1'b0;
               state_d    = ST_ISSUE;
               tx_reg_d   = TxRegWidth'(cur_frame);
            end else begin
               state_d   = ST_ERROR;
               err_idx_d = idx_q;
            end
`else
            advance = 1'b1;
`endif
            if (advance) begin
               if (is_last) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d    = idx_q + 1'b1;
                  state_d  = ST_ISSUE;
                  tx_reg_d = TxRegWidth'(nxt_frame);
`ifdef ADC_INIT_READBACK_EN
                  retry_d    = '0;
                  rd_phase_d = 1'b0;
`endif
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign tx_reg_o         = tx_reg_q;
   assign transfer_start_o = (state_q == ST_ISSUE) || (state_q == ST_ISSUE_RD);
   assign busy_o           = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
   assign config_done_o    = (state_q == ST_DONE);
   assign error_o          = (state_q == ST_ERROR);
   assign err_idx_o        = err_idx_q;

endmodule
